// File: rtl/pc_unit_if.sv
// pc_unit_if
//   Groups the fetch-stage control inputs and the PC/RAS status outputs of
//   pc_unit into one bundle. Clock and reset remain plain ports on pc_unit.
//
//   Control (driven by the pipeline, master -> slave):
//     i_stall, i_redirect_valid, i_redirect_pc, i_call, i_ret,
//     i_trap, i_trap_vector, i_halt, i_resume
//   Status (driven by pc_unit, slave -> master):
//     current_pc, o_pc_plus4, o_pc_valid, o_misaligned,
//     o_ras_top, o_ras_empty, o_ras_full, o_ras_mispredict
interface pc_unit_if #(
  parameter int XLEN = 32
);

  logic            i_stall;
  logic            i_redirect_valid;
  logic [XLEN-1:0] i_redirect_pc;
  logic            i_call;
  logic            i_ret;
  logic            i_trap;
  logic [XLEN-1:0] i_trap_vector;
  logic            i_halt;
  logic            i_resume;

  logic [XLEN-1:0] current_pc;
  logic [XLEN-1:0] o_pc_plus4;
  logic            o_pc_valid;
  logic            o_misaligned;
  logic [XLEN-1:0] o_ras_top;
  logic            o_ras_empty;
  logic            o_ras_full;
  logic            o_ras_mispredict;

  modport master (
    output i_stall, i_redirect_valid, i_redirect_pc, i_call, i_ret,
           i_trap, i_trap_vector, i_halt, i_resume,
    input  current_pc, o_pc_plus4, o_pc_valid, o_misaligned,
           o_ras_top, o_ras_empty, o_ras_full, o_ras_mispredict
  );

  modport slave (
    input  i_stall, i_redirect_valid, i_redirect_pc, i_call, i_ret,
           i_trap, i_trap_vector, i_halt, i_resume,
    output current_pc, o_pc_plus4, o_pc_valid, o_misaligned,
           o_ras_top, o_ras_empty, o_ras_full, o_ras_mispredict
  );

endinterface

// File: rtl/pc_unit.sv
// pc_unit
//   Program-counter unit for the fetch stage. Holds the architectural PC and
//   picks the next PC from trap vector, branch/jump redirect or sequential
//   increment, with stall and halt/resume support. A small circular
//   return-address stack (RAS) predicts return targets and flags returns
//   whose actual target disagrees with the prediction.
//
//   Ports:
//     i_clk  - clock, all state changes on the rising edge
//     i_rst  - synchronous active-high reset
//     bus    - pc_unit_if slave: control inputs and PC/RAS status outputs
//
//   Parameters:
//     XLEN         - PC width (>= 8)
//     RESET_VECTOR - PC after reset (4-byte aligned)
//     RAS_DEPTH    - RAS entries (>= 2, power of two)
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4
) (
  input logic        i_clk,
  input logic        i_rst,
  pc_unit_if.slave   bus
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misaligned_q, misaligned_d;
  logic            mispredict_q, mispredict_d;

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
  logic             ras_we;
  logic [PTR_W-1:0] ras_widx;
  logic [XLEN-1:0]  ras_wdata;

  // Intermediate pointer/count after the pop half of a return, so that a
  // combined call+return can apply the push on top of the popped state.
  logic [PTR_W-1:0] ptr_pop;
  logic [CNT_W-1:0] cnt_pop;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] ras_top;

  assign pc_plus4 = pc_q + XLEN'(4);
  // ras_ptr_q always indexes the most recent push; when empty the stale entry
  // is hidden so the prediction reads as zero.
  assign ras_top  = (ras_cnt_q == '0) ? '0 : ras_mem[ras_ptr_q];

  // State, PC, RAS bookkeeping and the registered one-cycle pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      misaligned_q <= 1'b0;
      mispredict_q <= 1'b0;
      ras_ptr_q    <= '0;
      ras_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
      mispredict_q <= mispredict_d;
      ras_ptr_q    <= ras_ptr_d;
      ras_cnt_q    <= ras_cnt_d;
    end
  end

  // RAS storage needs no reset: entries beyond the count are never observed.
  always_ff @(posedge i_clk) begin
    if (!i_rst && ras_we) begin
      ras_mem[ras_widx] <= ras_wdata;
    end
  end

  // Next-state / next-PC selection. Trap outranks stall, and both outrank the
  // HALT hold, so a trap always pulls the hart back into RUN.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misaligned_d = 1'b0;
    mispredict_d = 1'b0;
    ras_ptr_d    = ras_ptr_q;
    ras_cnt_d    = ras_cnt_q;
    ras_we       = 1'b0;
    ras_widx     = ras_ptr_q;
    ras_wdata    = pc_plus4;
    ptr_pop      = ras_ptr_q;
    cnt_pop      = ras_cnt_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end

      default: begin
        if (bus.i_trap) begin
          pc_d    = {bus.i_trap_vector[XLEN-1:2], 2'b00};
          state_d = RUN;
        end else if (bus.i_stall) begin
          pc_d = pc_q;
        end else if (state_q == HALT) begin
          if (bus.i_resume) begin
            state_d = RUN;
          end
        end else begin
          if (bus.i_redirect_valid) begin
            if (bus.i_redirect_pc[1:0] != 2'b00) begin
              misaligned_d = 1'b1;
            end else begin
              pc_d = bus.i_redirect_pc;
              if (bus.i_ret) begin
                mispredict_d = (ras_cnt_q == '0) || (bus.i_redirect_pc != ras_top);
                if (ras_cnt_q != '0) begin
                  ptr_pop = ras_ptr_q - PTR_W'(1);
                  cnt_pop = ras_cnt_q - CNT_W'(1);
                end
              end
              ras_ptr_d = ptr_pop;
              ras_cnt_d = cnt_pop;
              if (bus.i_call) begin
                // Pointer wraps naturally, so a push when full overwrites the
                // oldest entry while the count saturates.
                ras_we    = 1'b1;
                ras_widx  = ptr_pop + PTR_W'(1);
                ras_ptr_d = ptr_pop + PTR_W'(1);
                ras_cnt_d = (cnt_pop == DEPTH_C) ? DEPTH_C : cnt_pop + CNT_W'(1);
              end
            end
          end else begin
            pc_d = pc_plus4;
          end
          if (bus.i_halt) begin
            state_d = HALT;
          end
        end
      end
    endcase
  end

  assign bus.current_pc       = pc_q;
  assign bus.o_pc_plus4       = pc_plus4;
  assign bus.o_pc_valid       = (state_q == RUN);
  assign bus.o_misaligned     = misaligned_q;
  assign bus.o_ras_top        = ras_top;
  assign bus.o_ras_empty      = (ras_cnt_q == '0);
  assign bus.o_ras_full       = (ras_cnt_q == DEPTH_C);
  assign bus.o_ras_mispredict = mispredict_q;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit that replaces the single-register PC in the hart's fetch stage. It holds the architectural PC and selects the next PC from sequential increment, branch/jump redirect, or trap vector. It supports stall, halt/resume and a programmable reset vector. It also contains a small circular return-address stack (RAS) that predicts return targets and checks those predictions against the real target.

## Interface
- XLEN, 32, PC and address width (≥8)
- RESET_VECTOR, 0, value loaded into current_pc on reset; must be 4-byte aligned
- RAS_DEPTH, 4, number of return-address entries (≥2, power of two)

- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_stall  in  1  hold PC, state and RAS this cycle (trap still taken)
- i_redirect_valid  in  1  branch/jump taken this cycle
- i_redirect_pc  in  XLEN  redirect target
- i_call  in  1  qualifies redirect as call: push current_pc+4
- i_ret  in  1  qualifies redirect as return: pop and check
- i_trap  in  1  take trap
- i_trap_vector  in  XLEN  trap target; bits [1:0] forced to 0
- i_halt  in  1  request halt
- i_resume  in  1  leave HALT
- current_pc  out  XLEN  architectural PC (registered)
- o_pc_plus4  out  XLEN  current_pc+4, combinational, wraps mod 2^XLEN
- o_pc_valid  out  1  high only in RUN
- o_misaligned  out  1  registered one-cycle pulse: rejected misaligned redirect
- o_ras_top  out  XLEN  top RAS entry, 0 when empty
- o_ras_empty / o_ras_full  out  1  RAS occupancy flags
- o_ras_mispredict  out  1  registered one-cycle pulse: return target ≠ prediction or RAS empty

## Operation
- States: BOOT, RUN, HALT. Reset → BOOT. BOOT → RUN unconditionally after 1 cycle. In BOOT, all inputs except i_rst are ignored and current_pc holds.
- Reset values: current_pc=RESET_VECTOR, state=BOOT, RAS count=0, o_pc_valid=0, o_misaligned=0, o_ras_mispredict=0, o_ras_empty=1, o_ras_full=0, o_ras_top=0.
- Next-PC priority in RUN/HALT, highest first:
  1. i_trap: current_pc ← {i_trap_vector[XLEN-1:2],2'b00}. State → RUN. RAS unchanged.
  2. i_stall: everything holds.
  3. HALT: PC holds. i_resume → RUN next cycle; PC then continues from the held value.
  4. i_redirect_valid with i_redirect_pc[1:0]≠0: PC holds, o_misaligned pulses, RAS unchanged.
  5. i_redirect_valid aligned: current_pc ← i_redirect_pc. RAS actions for the redirect:
     - i_call: push current_pc+4.
     - i_ret: compare i_redirect_pc with top, then pop. o_ras_mispredict pulses on mismatch or if the RAS is empty.
     - i_call and i_ret both set: pop then push in the same cycle; count is unchanged and the top is replaced.
     - i_call/i_ret without i_redirect_valid are ignored.
  6. Otherwise current_pc ← current_pc+4, wrapping from 2^XLEN−4 to 0.
- i_halt in RUN, with no trap and no stall: the same cycle's PC update still happens, then state → HALT.
- RAS boundary behaviour:
  - Push when full overwrites the oldest entry (circular pointer); count saturates at RAS_DEPTH.
  - Pop when empty leaves count at 0.
  - Entries beyond count are don't-care; o_ras_top reads 0 when empty.

## Timing
- Redirect or trap asserted in cycle N → current_pc shows the target in cycle N+1.
- o_misaligned and o_ras_mispredict are high for exactly cycle N+1 after the offending event in N.
- o_pc_valid goes high 1 cycle after reset deasserts, falls the cycle after a halt request, and rises the cycle after i_resume or a trap.
- i_rst asserted mid-operation (in any state, during a stall or with a redirect pending) → reset values on the next edge; RAS contents flushed.
- o_pc_plus4 and the RAS flags/top derive only from registers; there are no input-to-output combinational paths.

## Test plan
- Reset with RESET_VECTOR=0x100, release reset, run 3 cycles → BOOT holds 0x100 with o_pc_valid=0, then 0x100, 0x104, 0x108 with o_pc_valid=1.
- Redirect to 0x2002 at PC 0x40 → PC stays 0x40, o_misaligned pulses 1 cycle. Redirect to 0x2000 → next PC 0x2000.
- Five calls at PCs 0x10/0x20/0x30/0x40/0x50 with RAS_DEPTH=4 → o_ras_full=1, top 0x54. Returns to 0x54, 0x44, 0x34, 0x24 → no mispredict. A fifth return → o_ras_mispredict=1, o_ras_empty=1.
- Trap (vector 0x803) asserted together with i_stall and a redirect while in HALT → PC 0x800, state RUN, o_pc_valid=1 next cycle.
- PC at 0xFFFFFFFC, no events → next PC 0x00000000. Stall held 3 cycles → PC and RAS unchanged throughout.
- i_rst asserted with RAS holding 2 entries during a redirect → PC=RESET_VECTOR, o_ras_empty=1, state BOOT.
